unidade_muldiv: RTL and testbench

- Iterative multi-cycle multiply/divide unit sitting beside the combinational ULA in the execute stage.
- Takes the same RS/RT operands and 5-bit operation code as the ULA.
- Computes 64-bit unsigned products or unsigned quotient/remainder over 32 iterations.
- Holds results in architectural HI/LO registers; raises ocupado so the control unit can stall the pipeline.

---
 rtl/unidade_muldiv_pkg.sv | 20 ++
 rtl/unidade_muldiv_passo_divisao.sv | 35 +++
 rtl/unidade_muldiv.sv | 167 ++++++++++++++++
 tb/tb_unidade_muldiv.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_muldiv_pkg.sv
// rtl/unidade_muldiv_pkg.sv - shared operation codes and FSM encoding for the mul/div unit
// Contents: ulaOP codes shared with the ULA, FSM state type, operation validity helper.
package unidade_muldiv_pkg;

   localparam logic [4:0] OP_MULTIPLICACAO = 5'b00010;
   localparam logic [4:0] OP_DIVISAO       = 5'b00011;
   localparam logic [4:0] OP_RESTO_DIVISAO = 5'b00100;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   // Only these three codes belong to this unit; every other code is the ULA's.
   function automatic logic op_valida(input logic [4:0] op);
      return (op == OP_MULTIPLICACAO) || (op == OP_DIVISAO) || (op == OP_RESTO_DIVISAO);
   endfunction

endpackage

// File: rtl/unidade_muldiv_passo_divisao.sv
// rtl/unidade_muldiv_passo_divisao.sv - one combinational restoring-division step
// Ports:
//   resto_i         partial remainder entering the step (always < divisor_i)
//   bit_entrada_i   next dividend bit shifted into the remainder
//   divisor_i       divisor
//   resto_o         partial remainder after the step
//   bit_quociente_o quotient bit produced by the step
module passo_divisao #(
   parameter int LARGURA = 32
) (
   input  logic [LARGURA-1:0] resto_i,
   input  logic               bit_entrada_i,
   input  logic [LARGURA-1:0] divisor_i,
   output logic [LARGURA-1:0] resto_o,
   output logic               bit_quociente_o
);

   logic [LARGURA:0] parcial;
   logic [LARGURA:0] diferenca;

   // parcial < 2*divisor, so the difference fits in LARGURA+1 bits and its
   // top bit is a reliable borrow flag.
   always_comb begin
      parcial   = {resto_i, bit_entrada_i};
      diferenca = parcial - {1'b0, divisor_i};
      if (!diferenca[LARGURA]) begin
         bit_quociente_o = 1'b1;
         resto_o         = diferenca[LARGURA-1:0];
      end else begin
         bit_quociente_o = 1'b0;
         resto_o         = parcial[LARGURA-1:0];
      end
   end

endmodule

// File: rtl/unidade_muldiv.sv
// rtl/unidade_muldiv.sv - iterative unsigned multiply/divide unit with HI/LO registers
// Ports:
//   clock, reset         rising-edge clock, synchronous active-low reset
//   inicio, ulaOP        start request and operation code (mul/div/rem)
//   RS, RT               operands (multiplicand/dividend, multiplier/divisor)
//   escreveHI/LO         mthi/mtlo: load HI/LO from RS while idle
//   ocupado, pronto      busy level and one-cycle commit pulse
//   erroDiv              divide-by-zero flag of the last operation
//   saidaHI/LO/ULA       architectural HI, LO and selected result
module unidade_muldiv
   import unidade_muldiv_pkg::*;
#(
   parameter int LARGURA = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               inicio,
   input  logic [4:0]         ulaOP,
   input  logic [LARGURA-1:0] RS,
   input  logic [LARGURA-1:0] RT,
   input  logic               escreveHI,
   input  logic               escreveLO,
   output logic               ocupado,
   output logic               pronto,
   output logic               erroDiv,
   output logic [LARGURA-1:0] saidaHI,
   output logic [LARGURA-1:0] saidaLO,
   output logic [LARGURA-1:0] saidaULA
);

   localparam int ITERACOES = LARGURA;
   localparam int CW        = $clog2(ITERACOES);

   estado_t            estado_q, estado_d;
   logic [CW-1:0]      cont_q, cont_d;
   logic [4:0]         op_q, op_d;
   logic [LARGURA-1:0] operando_q, operando_d;
   // acc_hi/acc_lo are the working pair: product halves for multiply,
   // remainder/quotient (quotient shifting in as dividend shifts out) for divide.
   logic [LARGURA-1:0] acc_hi_q, acc_hi_d;
   logic [LARGURA-1:0] acc_lo_q, acc_lo_d;
   logic               div0_q, div0_d;
   logic [LARGURA-1:0] hi_q, hi_d;
   logic [LARGURA-1:0] lo_q, lo_d;
   logic [LARGURA-1:0] ula_q, ula_d;
   logic               pronto_q, pronto_d;
   logic               erro_q, erro_d;

   logic [LARGURA:0]   soma;
   logic [LARGURA-1:0] resto_novo;
   logic               bit_quociente;

   passo_divisao #(.LARGURA(LARGURA)) u_passo (
      .resto_i         (acc_hi_q),
      .bit_entrada_i   (acc_lo_q[LARGURA-1]),
      .divisor_i       (operando_q),
      .resto_o         (resto_novo),
      .bit_quociente_o (bit_quociente)
   );

   always_comb begin
      estado_d   = estado_q;
      cont_d     = cont_q;
      op_d       = op_q;
      operando_d = operando_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      div0_d     = div0_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      ula_d      = ula_q;
      pronto_d   = 1'b0;
      erro_d     = erro_q;
      // Shift-add: add multiplicand to the high half when the multiplier LSB
      // (held in acc_lo) is set, then shift the whole 65-bit value right.
      soma = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operando_q} : '0);

      case (estado_q)
         OCIOSO: begin
            if (escreveHI) hi_d = RS;
            if (escreveLO) lo_d = RS;
            if (inicio && op_valida(ulaOP)) begin
               erro_d = 1'b0;
               op_d   = ulaOP;
               cont_d = '0;
               if (ulaOP == OP_MULTIPLICACAO) begin
                  operando_d = RS;
                  acc_hi_d   = '0;
                  acc_lo_d   = RT;
                  div0_d     = 1'b0;
                  estado_d   = CALCULA;
               end else if (RT == '0) begin
                  // Divide-by-zero result is known now; FIM just commits it.
                  acc_hi_d = RS;
                  acc_lo_d = '1;
                  div0_d   = 1'b1;
                  estado_d = FIM;
               end else begin
                  operando_d = RT;
                  acc_hi_d   = '0;
                  acc_lo_d   = RS;
                  div0_d     = 1'b0;
                  estado_d   = CALCULA;
               end
            end
         end
         CALCULA: begin
            if (op_q == OP_MULTIPLICACAO) begin
               acc_hi_d = soma[LARGURA:1];
               acc_lo_d = {soma[0], acc_lo_q[LARGURA-1:1]};
            end else begin
               acc_hi_d = resto_novo;
               acc_lo_d = {acc_lo_q[LARGURA-2:0], bit_quociente};
            end
            cont_d = cont_q + CW'(1);
            if (cont_q == CW'(ITERACOES - 1)) estado_d = FIM;
         end
         FIM: begin
            hi_d     = acc_hi_q;
            lo_d     = acc_lo_q;
            ula_d    = (op_q == OP_RESTO_DIVISAO) ? acc_hi_q : acc_lo_q;
            pronto_d = 1'b1;
            erro_d   = div0_q;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q   <= OCIOSO;
         cont_q     <= '0;
         op_q       <= '0;
         operando_q <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         div0_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         ula_q      <= '0;
         pronto_q   <= 1'b0;
         erro_q     <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cont_q     <= cont_d;
         op_q       <= op_d;
         operando_q <= operando_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         div0_q     <= div0_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         ula_q      <= ula_d;
         pronto_q   <= pronto_d;
         erro_q     <= erro_d;
      end
   end

   assign ocupado  = (estado_q != OCIOSO);
   assign pronto   = pronto_q;
   assign erroDiv  = erro_q;
   assign saidaHI  = hi_q;
   assign saidaLO  = lo_q;
   assign saidaULA = ula_q;

endmodule

// File: tb/tb_unidade_muldiv.sv
// tb/tb_unidade_muldiv.sv - directed self-checking bench for unidade_muldiv
module tb_unidade_muldiv;

   localparam logic [4:0] MUL = 5'b00010;
   localparam logic [4:0] DIV = 5'b00011;
   localparam logic [4:0] REM = 5'b00100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        inicio = 1'b0;
   logic [4:0]  ulaOP = 5'b0;
   logic [31:0] RS = 32'd0;
   logic [31:0] RT = 32'd0;
   logic        escreveHI = 1'b0;
   logic        escreveLO = 1'b0;
   logic        ocupado, pronto, erroDiv;
   logic [31:0] saidaHI, saidaLO, saidaULA;

   int checks = 0;
   int failures = 0;
   int lat, busy;
   bit mudou;

   unidade_muldiv #(.LARGURA(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .inicio    (inicio),
      .ulaOP     (ulaOP),
      .RS        (RS),
      .RT        (RT),
      .escreveHI (escreveHI),
      .escreveLO (escreveLO),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .erroDiv   (erroDiv),
      .saidaHI   (saidaHI),
      .saidaLO   (saidaLO),
      .saidaULA  (saidaULA)
   );

   always #5 clock = ~clock;

   // Starts an operation and runs until pronto (bounded). At cycle pk it may
   // drive a stray inicio and/or escreveHI with new operands.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int pk, input logic p_ini, input logic p_whi,
                         output int lat_o, output int busy_o, output bit mudou_o);
      logic [31:0] hi0, lo0, ula0;
      hi0 = saidaHI; lo0 = saidaLO; ula0 = saidaULA;
      lat_o = 0; busy_o = 0; mudou_o = 1'b0;
      ulaOP = op; RS = a; RT = b; inicio = 1'b1;
      for (int k = 1; k <= 100 && lat_o == 0; k++) begin
         @(negedge clock);
         inicio = 1'b0;
         escreveHI = 1'b0;
         if (k == pk) begin
            inicio = p_ini;
            escreveHI = p_whi;
            RS = 32'hABCD0000;
            RT = 32'd9;
         end
         if (pronto) lat_o = k;
         else begin
            if (ocupado) busy_o++;
            if (saidaHI !== hi0 || saidaLO !== lo0 || saidaULA !== ula0) mudou_o = 1'b1;
         end
      end
      inicio = 1'b0;
      escreveHI = 1'b0;
      checks++;
      if (lat_o == 0) begin
         failures++;
         $display("FAIL run_timeout: got no pronto in 100 cycles, required pronto");
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; inicio = 1'b1; ulaOP = MUL; RS = 32'd5; RT = 32'd6;
      repeat (2) @(negedge clock);
      reset = 1'b1; inicio = 1'b0;
      @(negedge clock);
      checks++;
      if ({ocupado, pronto, erroDiv} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b required 000", {ocupado, pronto, erroDiv});
      end
      checks++;
      if (saidaHI !== 32'd0 || saidaLO !== 32'd0 || saidaULA !== 32'd0) begin
         failures++;
         $display("FAIL reset_regs: got %h %h %h required zeros", saidaHI, saidaLO, saidaULA);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (ocupado !== 1'b0 || pronto !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got ocupado=%b pronto=%b required 0 0", ocupado, pronto);
      end
   endtask

   task automatic test_multiply();
      run_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 1'b0, lat, busy, mudou);
      checks++;
      if (lat != 34) begin failures++; $display("FAIL mul_latency: got %0d required 34", lat); end
      checks++;
      if (busy != 33) begin failures++; $display("FAIL mul_busy: got %0d required 33", busy); end
      checks++;
      if (mudou) begin failures++; $display("FAIL mul_hold: got outputs changed during op required hold"); end
      checks++;
      if (saidaHI !== 32'hFFFFFFFE || saidaLO !== 32'h00000001 || saidaULA !== 32'h00000001) begin
         failures++;
         $display("FAIL mul_result: got %h %h %h required fffffffe 00000001 00000001", saidaHI, saidaLO, saidaULA);
      end
      checks++;
      if (ocupado !== 1'b0 || erroDiv !== 1'b0) begin
         failures++;
         $display("FAIL mul_flags: got ocupado=%b erroDiv=%b required 0 0", ocupado, erroDiv);
      end
      @(negedge clock);
      checks++;
      if (pronto !== 1'b0) begin failures++; $display("FAIL mul_pulse: got pronto=%b required 0", pronto); end
   endtask

   task automatic test_divide();
      run_op(DIV, 32'd100, 32'd7, 0, 1'b0, 1'b0, lat, busy, mudou);
      checks++;
      if (lat != 34) begin failures++; $display("FAIL div_latency: got %0d required 34", lat); end
      checks++;
      if (mudou) begin failures++; $display("FAIL div_hold: got outputs changed during op required hold"); end
      checks++;
      if (saidaLO !== 32'd14 || saidaHI !== 32'd2 || saidaULA !== 32'd14) begin
         failures++;
         $display("FAIL div_result: got %0d %0d %0d required 14 2 14", saidaLO, saidaHI, saidaULA);
      end
      @(negedge clock);
      run_op(REM, 32'd100, 32'd7, 0, 1'b0, 1'b0, lat, busy, mudou);
      checks++;
      if (saidaULA !== 32'd2 || saidaLO !== 32'd14 || saidaHI !== 32'd2) begin
         failures++;
         $display("FAIL rem_result: got ula=%0d lo=%0d hi=%0d required 2 14 2", saidaULA, saidaLO, saidaHI);
      end
      @(negedge clock);
   endtask

   task automatic test_div_zero();
      run_op(DIV, 32'h12345678, 32'd0, 0, 1'b0, 1'b0, lat, busy, mudou);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL div0_latency: got %0d required 2", lat); end
      checks++;
      if (saidaLO !== 32'hFFFFFFFF || saidaHI !== 32'h12345678 || erroDiv !== 1'b1) begin
         failures++;
         $display("FAIL div0_result: got lo=%h hi=%h err=%b required ffffffff 12345678 1", saidaLO, saidaHI, erroDiv);
      end
      @(negedge clock);
      run_op(MUL, 32'd3, 32'd5, 0, 1'b0, 1'b0, lat, busy, mudou);
      checks++;
      if (erroDiv !== 1'b0 || saidaLO !== 32'd15 || saidaHI !== 32'd0) begin
         failures++;
         $display("FAIL div0_clear: got err=%b lo=%0d hi=%0d required 0 15 0", erroDiv, saidaLO, saidaHI);
      end
      @(negedge clock);
   endtask

   task automatic test_ignore_inicio();
      run_op(MUL, 32'd1000, 32'd2000, 10, 1'b1, 1'b0, lat, busy, mudou);
      checks++;
      if (lat != 34) begin failures++; $display("FAIL ignore_latency: got %0d required 34", lat); end
      checks++;
      if (saidaLO !== 32'h001E8480 || saidaHI !== 32'd0) begin
         failures++;
         $display("FAIL ignore_result: got hi=%h lo=%h required 00000000 001e8480", saidaHI, saidaLO);
      end
      @(negedge clock);
      checks++;
      if (ocupado !== 1'b0) begin failures++; $display("FAIL ignore_idle: got ocupado=%b required 0", ocupado); end
   endtask

   task automatic test_escreve();
      run_op(MUL, 32'd3, 32'd5, 5, 1'b0, 1'b1, lat, busy, mudou);
      checks++;
      if (mudou) begin failures++; $display("FAIL wr_busy_ignored: got HI/LO changed during op required hold"); end
      checks++;
      if (saidaHI !== 32'd0 || saidaLO !== 32'd15) begin
         failures++;
         $display("FAIL wr_busy_result: got hi=%h lo=%0d required 0 15", saidaHI, saidaLO);
      end
      @(negedge clock);
      RS = 32'hABCD0000; escreveHI = 1'b1;
      @(negedge clock);
      escreveHI = 1'b0;
      checks++;
      if (saidaHI !== 32'hABCD0000 || saidaLO !== 32'd15 || saidaULA !== 32'd15) begin
         failures++;
         $display("FAIL wr_idle: got hi=%h lo=%0d ula=%0d required abcd0000 15 15", saidaHI, saidaLO, saidaULA);
      end
   endtask

   task automatic test_reset_abort();
      bit viu_pronto;
      ulaOP = DIV; RS = 32'd1000; RT = 32'd3; inicio = 1'b1;
      @(negedge clock);
      inicio = 1'b0;
      repeat (19) @(negedge clock);
      checks++;
      if (ocupado !== 1'b1) begin failures++; $display("FAIL abort_busy: got ocupado=%b required 1", ocupado); end
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      checks++;
      if (saidaHI !== 32'd0 || saidaLO !== 32'd0 || ocupado !== 1'b0) begin
         failures++;
         $display("FAIL abort_clear: got hi=%h lo=%h ocupado=%b required 0 0 0", saidaHI, saidaLO, ocupado);
      end
      viu_pronto = 1'b0;
      repeat (50) begin
         @(negedge clock);
         if (pronto) viu_pronto = 1'b1;
      end
      checks++;
      if (viu_pronto || saidaLO !== 32'd0) begin
         failures++;
         $display("FAIL abort_no_commit: got pronto_seen=%b lo=%h required 0 0", viu_pronto, saidaLO);
      end
      run_op(DIV, 32'd1000, 32'd3, 0, 1'b0, 1'b0, lat, busy, mudou);
      checks++;
      if (saidaLO !== 32'd333 || saidaHI !== 32'd1 || lat != 34) begin
         failures++;
         $display("FAIL abort_recover: got lo=%0d hi=%0d lat=%0d required 333 1 34", saidaLO, saidaHI, lat);
      end
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_div_zero();
      test_ignore_inicio();
      test_escreve();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
